// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker.
// Holds the receive FSM state encoding used by serial_parity_checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/parity_accum.sv
// Running XOR accumulator: one xor gate feeding one flop.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset, clears the accumulator
//   clear      - synchronous clear (takes priority over en)
//   en         - fold bit_in into the accumulator this cycle
//   bit_in     - bit to accumulate
//   parity_out - XOR of all bits accumulated since the last clear
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic parity_out
);

  logic nxt;

  xor u_xor (nxt, parity_out, bit_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        parity_out <= 1'b0;
    else if (clear) parity_out <= 1'b0;
    else if (en)    parity_out <= nxt;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver with parity check.
// Frame: start bit (0), DATA_W data bits LSB first, one parity bit.
// Only cycles with in_valid=1 carry bits.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   clr        - synchronous frame abort (results are kept)
//   in_valid   - in_bit is meaningful this cycle
//   in_bit     - serial line bit
//   out_data   - data word of the last completed frame
//   out_valid  - one-cycle strobe after each completed frame
//   parity_err - parity result of the last completed frame
//   busy       - a frame is in progress
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              parity_err,
  output logic              busy
);

  localparam int            CW   = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                acc_clear, acc_en, acc, done;

  parity_accum u_accum (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .en         (acc_en),
    .bit_in     (in_bit),
    .parity_out (acc)
  );

  // clr is evaluated first so it also beats a parity bit arriving the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    done      = 1'b0;
    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      acc_clear = 1'b1;
    end else if (in_valid) begin
      case (state_q)
        IDLE: if (!in_bit) begin
          state_d   = DATA;
          cnt_d     = '0;
          acc_clear = 1'b1;
        end
        DATA: begin
          data_d = {in_bit, data_q[DATA_W-1:1]};
          acc_en = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = PARITY;
        end
        PARITY: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      out_valid <= done;
      if (done) begin
        out_data   <= data_q;
        parity_err <= acc ^ in_bit ^ ODD;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, clr, in_valid, in_bit;
  logic [W-1:0] d_e, d_o;
  logic         v_e, v_o, e_e, e_o, b_e, b_o;

  int vectors = 0, errors = 0, strobes = 0, busy_low = 0;
  bit in_frame = 1'b0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(W), .ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .out_data(d_e), .out_valid(v_e), .parity_err(e_e), .busy(b_e));

  serial_parity_checker #(.DATA_W(W), .ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .out_data(d_o), .out_valid(v_o), .parity_err(e_o), .busy(b_o));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at negedge; return just after the following posedge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v; in_bit = b; clr = c;
    @(posedge clk);
    #1;
    if (v_e) strobes++;
    if (in_frame && !b_e) busy_low++;
  endtask

  task automatic gap(input int lo, input int hi);
    int n;
    n = int'($urandom_range(hi, lo));
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0);
  endtask

  // Start bit plus the first nbits data bits of w, LSB first.
  task automatic send_bits(input logic [W-1:0] w, input int nbits, input int lo, input int hi);
    gap(lo, hi);
    step(1'b1, 1'b0, 1'b0);
    chk("start_busy", 32'(b_e), 32'd1);
    chk("strobe_len", 32'(v_e), 32'd0);
    in_frame = 1'b1;
    busy_low = 0;
    for (int i = 0; i < nbits; i++) begin
      gap(lo, hi);
      step(1'b1, w[i], 1'b0);
    end
  endtask

  // Full frame; expected parity_err from the frame itself: XOR of all data and parity bits, flipped for odd.
  task automatic send_frame(input logic [W-1:0] w, input logic p, input int lo, input int hi);
    logic ex_e, ex_o;
    ex_e = (^w) ^ p;
    ex_o = ~ex_e;
    send_bits(w, W, lo, hi);
    gap(lo, hi);
    in_frame = 1'b0;
    chk("busy_in_frame", 32'(busy_low), 32'd0);
    step(1'b1, p, 1'b0);
    chk("valid_e", 32'(v_e), 32'd1);
    chk("valid_o", 32'(v_o), 32'd1);
    chk("data_e", 32'(d_e), 32'(w));
    chk("data_o", 32'(d_o), 32'(w));
    chk("perr_e", 32'(e_e), 32'(ex_e));
    chk("perr_o", 32'(e_o), 32'(ex_o));
    chk("busy_done", 32'(b_e), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    logic [W-1:0] w;
    logic p;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    #12;
    chk("rst_data", 32'(d_e), 32'd0);
    chk("rst_valid", 32'(v_e), 32'd0);
    chk("rst_perr", 32'(e_e), 32'd0);
    chk("rst_busy", 32'(b_e), 32'd0);
    @(negedge clk); rst = 1'b0;

    // idle 1s are ignored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("idle_ones", 32'(b_e), 32'd0);
    chk("idle_strobe", 32'(strobes), 32'd0);

    // directed frames
    send_frame(8'hA5, 1'b0, 0, 0);
    chk("a5_even_err", 32'(e_e), 32'd0);
    send_frame(8'hA5, 1'b1, 0, 0);
    chk("a5_p1_err", 32'(e_e), 32'd1);
    send_frame(8'h01, 1'b0, 0, 0);
    chk("odd_01_err", 32'(e_o), 32'd0);
    send_frame(8'h00, 1'b0, 0, 0);
    chk("odd_00_err", 32'(e_o), 32'd1);
    send_frame(8'h3C, 1'b0, 1, 3);

    // abort after 4 data bits, then a full frame: exactly one strobe
    s0 = strobes;
    send_bits(8'hFF, 4, 0, 0);
    in_frame = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    chk("clr_busy", 32'(b_e), 32'd0);
    chk("clr_keep_data", 32'(d_e), 32'h3C);
    chk("clr_keep_perr", 32'(e_e), 32'd0);
    send_frame(8'h81, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_strobes", 32'(strobes - s0), 32'd1);

    // clr beats a simultaneous parity bit
    s0 = strobes;
    send_bits(8'h5A, W, 0, 0);
    in_frame = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_par_strobe", 32'(strobes - s0), 32'd0);
    chk("clr_par_busy", 32'(b_e), 32'd0);
    chk("clr_par_data", 32'(d_e), 32'h81);

    // async reset mid-frame
    send_frame(8'hA5, 1'b0, 0, 0);
    send_bits(8'h77, 3, 0, 0);
    in_frame = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_data", 32'(d_e), 32'd0);
    chk("arst_valid", 32'(v_e), 32'd0);
    chk("arst_perr", 32'(e_e), 32'd0);
    chk("arst_busy", 32'(b_e), 32'd0);
    chk("arst_busy_o", 32'(b_o), 32'd0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    send_frame(8'h0F, 1'b0, 0, 0);

    // randomized frames, some back-to-back, with ignored idle 1s
    for (int f = 0; f < 40; f++) begin
      w = W'($urandom);
      p = 1'($urandom);
      if ($urandom_range(3, 0) == 0)
        for (int i = 0; i < int'($urandom_range(3, 1)); i++) step(1'b1, 1'b1, 1'b0);
      if ($urandom_range(1, 0) == 0) send_frame(w, p, 0, 0);
      else                           send_frame(w, p, 0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (range 2..16).
REQ-002 SHALL have parameter ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port clr, input, 1, synchronous frame abort.
REQ-006 SHALL have port in_valid, input, 1, qualifies in_bit for the current cycle.
REQ-007 SHALL have port in_bit, input, 1, serial line bit.
REQ-008 SHALL have port out_data, output, DATA_W, last received data word.
REQ-009 SHALL have port out_valid, output, 1, one-cycle frame-complete strobe.
REQ-010 SHALL have port parity_err, output, 1, parity result of last completed frame.
REQ-011 SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-012 Frame format SHALL be one start bit (0), DATA_W data bits LSB first, one parity bit; only cycles with in_valid=1 count as bits.
REQ-013 FSM SHALL have states IDLE, DATA, PARITY.
REQ-014 IDLE: in_valid=1 with in_bit=1 SHALL be ignored; in_valid=1 with in_bit=0 SHALL go to DATA, clearing bit counter and parity accumulator.
REQ-015 DATA: each valid bit SHALL shift into the data register (LSB first), XOR into the accumulator, increment the counter; on the DATA_W-th valid bit, go to PARITY.
REQ-016 PARITY: the next valid bit SHALL complete the frame and return to IDLE.
REQ-017 On frame completion, parity_err SHALL equal accumulator XOR parity bit XOR ODD, out_data SHALL load the assembled word, out_valid SHALL be high for exactly the following cycle.
REQ-018 out_data and parity_err SHALL hold their values until the next frame completion.
REQ-019 busy SHALL be high in DATA and PARITY, low in IDLE.
REQ-020 in_valid=0 cycles SHALL leave state, counter, accumulator and data register unchanged.
REQ-021 clr=1 SHALL force IDLE and clear counter/accumulator at the next edge with no out_valid; clr wins over a simultaneous parity bit.
REQ-022 clr SHALL NOT alter out_data or parity_err.
REQ-023 A start bit arriving in the cycle out_valid is high SHALL be accepted (back-to-back frames, no gap required).
REQ-024 Bit counter width SHALL be $clog2(DATA_W+1); no wrap beyond DATA_W.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, counter=0, accumulator=0, data register=0, out_data=0, out_valid=0, parity_err=0, busy=0, including mid-frame.
REQ-026 After rst deasserts, the first valid 0 bit SHALL be treated as a start bit.

Structure
REQ-027 FSM state encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2) SHALL live in the shared package parity_pkg.
REQ-028 Running XOR SHALL be a sub-module parity_accum (clk, rst, clear, en, bit_in, parity_out) built on a xor primitive plus flop.

Verification
REQ-029 Even, frame 0,0xA5 LSB-first,0 -> out_valid one cycle, out_data=0xA5, parity_err=0.
REQ-030 Even, frame 0,0xA5,1 -> out_data=0xA5, parity_err=1.
REQ-031 ODD=1, frame 0,0x01,0 -> parity_err=0; frame 0,0x00,0 -> parity_err=1.
REQ-032 Even, 0x3C with in_valid=0 gaps of 1..3 cycles between bits -> out_data=0x3C, parity_err=0, busy high throughout.
REQ-033 clr after 4 data bits, then full frame 0x81 -> single out_valid, out_data=0x81, no strobe for aborted frame.
REQ-034 rst asserted mid-frame after prior result 0xA5 -> all outputs 0 immediately; following frame 0x0F decodes correctly.
